shift_sequencer: RTL

Sequential front end for the 32-bit logical barrel shifter (Barrel_Shifter). Accepts shift/rotate commands over a valid/ready interface and buffers them in a small FIFO. Drives the shifter's SH_DIR/SH_AMT/D_IN, and returns the registered result with a tag over a valid/ready interface. Rotates are built from two shifter passes OR-combined, so the shifter stays purely logical.

---
 rtl/shift_sequencer_pkg.sv | 23 ++
 rtl/shift_cmd_fifo.sv | 50 +++++
 rtl/shift_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared widths, op codes and FSM states for shift_sequencer
package shift_sequencer_pkg;

  localparam int WIDTH  = 5;
  localparam int WIDTH2 = 32;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS1  = 2'd1,
    ST_PASS2  = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  function automatic logic is_rotate(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// rtl/shift_cmd_fifo.sv - synchronous command FIFO with full/empty from a registered count
module shift_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // a full FIFO refuses a push even when a pop happens in the same cycle
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - queued shift/rotate sequencer driving an external logical barrel shifter
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [WIDTH-1:0]  REQ_AMT,
  input  logic [WIDTH2-1:0] REQ_DATA,
  input  logic [TAG_W-1:0]  REQ_TAG,
  output logic              SH_DIR,
  output logic [WIDTH-1:0]  SH_AMT,
  output logic [WIDTH2-1:0] SH_DIN,
  input  logic [WIDTH2-1:0] SH_DOUT,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [WIDTH2-1:0] RES_DATA,
  output logic [TAG_W-1:0]  RES_TAG,
  output logic              BUSY
);

  localparam int CMD_W = 2 + WIDTH + WIDTH2 + TAG_W;

  state_e            state;
  logic              full;
  logic              empty;
  logic [CMD_W-1:0]  head;
  logic [1:0]        h_op;
  logic [WIDTH-1:0]  h_amt;
  logic [WIDTH2-1:0] h_data;
  logic [TAG_W-1:0]  h_tag;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  amt_q;
  logic [WIDTH2-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WIDTH2-1:0] acc;

  assign REQ_READY = !full && !RST;
  assign BUSY      = (state != ST_IDLE) || !empty;
  assign {h_op, h_amt, h_data, h_tag} = head;

  shift_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (REQ_VALID && REQ_READY),
    .push_data ({REQ_OP, REQ_AMT, REQ_DATA, REQ_TAG}),
    .pop       (state == ST_IDLE),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Shifter inputs are registered one state ahead so they are valid throughout PASS1/PASS2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      op_q      <= OP_SLL;
      amt_q     <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      acc       <= '0;
      SH_DIR    <= 1'b0;
      SH_AMT    <= '0;
      SH_DIN    <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_TAG   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            op_q   <= h_op;
            amt_q  <= h_amt;
            data_q <= h_data;
            tag_q  <= h_tag;
            SH_DIR <= h_op[0];
            SH_AMT <= h_amt;
            SH_DIN <= h_data;
            state  <= ST_PASS1;
          end
        end
        ST_PASS1: begin
          acc <= SH_DOUT;
          if (is_rotate(op_q) && amt_q != '0) begin
            // second pass shifts the opposite way by 32-amt; OR-ing both passes forms the rotate
            SH_DIR <= !op_q[0];
            SH_AMT <= -amt_q;
            SH_DIN <= data_q;
            state  <= ST_PASS2;
          end else begin
            SH_DIR    <= 1'b0;
            SH_AMT    <= '0;
            SH_DIN    <= '0;
            RES_VALID <= 1'b1;
            RES_DATA  <= SH_DOUT;
            RES_TAG   <= tag_q;
            state     <= ST_RESULT;
          end
        end
        ST_PASS2: begin
          acc       <= acc | SH_DOUT;
          SH_DIR    <= 1'b0;
          SH_AMT    <= '0;
          SH_DIN    <= '0;
          RES_VALID <= 1'b1;
          RES_DATA  <= acc | SH_DOUT;
          RES_TAG   <= tag_q;
          state     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
